time_set_unit: RTL
==================

# time_set_unit

Parametrised hh:mm:ss setting unit for the clock/timer labs. It holds three two-digit BCD fields (seconds, minutes, hours) and steps the currently selected field up or down from debounced push-buttons, with auto-repeat while a button is held. The wrap modulus of every field is configurable, and a parallel load path presets all three fields. Outputs feed the display mux and provide the reload values for the countdown/clock counters.

## Interface
Parameters:
- SEC_MOD, 60, seconds wrap modulus (2..99); field range 00..SEC_MOD-1
- MIN_MOD, 60, minutes wrap modulus (2..99)
- HR_MOD, 24, hours wrap modulus (2..99)
- RPT_DELAY, 25_000_000, clk cycles from first step to first auto-repeat step (>=2)
- RPT_PERIOD, 5_000_000, clk cycles between subsequent auto-repeat steps (>=1)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- sel  in  1  one-cycle pulse; advance selected field sec->min->hr->sec
- inc  in  1  level, held button, already debounced/synchronised; step up
- dec  in  1  level, held button, already debounced/synchronised; step down
- load  in  1  one-cycle pulse; preset all fields from load_*
- load_sec, load_min, load_hr  in  8 each  BCD preset {tens, ones}
- val_sec, val_min, val_hr  out  8 each  BCD field values {tens, ones}
- field  out  2  selected field: 0 sec, 1 min, 2 hr (3 never produced)
- step  out  1  one-cycle pulse, high in the cycle after any field value changed by inc/dec

## Operation
- Reset: val_* = 8'h00, field = 0, step = 0, FSM = HOLD, inc/dec history regs = 1 (button held through reset produces no step until released).
- Direction: inc=1, dec=0 -> up; dec=1, inc=0 -> down; both or neither -> no request.
- FSM states:
  - IDLE: no request. Rising edge of a request (history shows no request last cycle) -> apply one step, load repeat counter with RPT_DELAY-1, go DELAY.
  - DELAY: request still active and same direction -> count down; at 0 apply step, reload RPT_PERIOD-1, go REPEAT. Request dropped -> IDLE.
  - REPEAT: same as DELAY, but reload with RPT_PERIOD-1 after each step.
  - HOLD: wait until inc=0 and dec=0, then go IDLE.
- Direction change, or both buttons pressed, while in DELAY/REPEAT -> HOLD (no step).
- sel pulse: field advances (2 -> 0); FSM forced to HOLD, so a held button must be released before the new field steps.
- Step arithmetic (selected field only, modulus M): up from M-1 -> 00, else +1 with BCD ones 9 -> 0 carrying into tens; down from 00 -> M-1, else -1 with ones 0 -> 9 borrowing from tens. No carry or borrow between fields.
- load: all three fields are written from load_* in the same cycle; a field whose digit is >9 or whose value is >=its modulus loads 00. field is unchanged; FSM -> HOLD.
- Priority: rst > load > sel > step. A step scheduled in the same cycle as load or sel is discarded.
- Fields always hold valid BCD values below their modulus.

## Timing
- Value update: registered; the edge that samples a new request writes val_*, visible the next cycle; step is high during that same visible cycle.
- Auto-repeat: with the first step at edge k, repeats occur at edges k+RPT_DELAY, k+RPT_DELAY+RPT_PERIOD, ...
- sel/load effects are visible one cycle after the sampling edge.
- No combinational path from any input to any output.

## Test plan
Benches use RPT_DELAY=8 and RPT_PERIOD=3.
- Reset, then a 1-cycle inc pulse on field 0 -> val_sec 8'h01, one step pulse. 59 further pulses -> 8'h59, then 8'h00 (wrap, val_min unchanged).
- sel twice, then a dec pulse -> field=2, val_hr 8'h00 -> 8'h23. Repeat with HR_MOD=12 -> 8'h11.
- inc held for 20 cycles on min at 8'h08 -> steps at relative edges 0, 8, 11, 14, 17 -> 8'h13; BCD carry 09->10 is correct.
- inc held and dec raised mid-repeat -> stepping stops (HOLD); dec released while inc is still held -> no step until inc is released and pressed again.
- load with {8'h45, 8'h7A, 8'h30} on default moduli -> val_sec 8'h45, val_min 8'h00, val_hr 8'h00. load coincident with an inc edge -> load values, no step.
- inc held across rst deassertion -> no step; after release and re-press -> one step. rst asserted mid-REPEAT -> all outputs 00 the next cycle.

Source files
------------

// File: rtl/time_set_unit.sv
// hh:mm:ss BCD setting unit: steps the selected field from held push-buttons
// with auto-repeat, and presets all fields from a parallel load path.
module time_set_unit #(
  parameter int SEC_MOD    = 60,
  parameter int MIN_MOD    = 60,
  parameter int HR_MOD     = 24,
  parameter int RPT_DELAY  = 25_000_000,
  parameter int RPT_PERIOD = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [7:0] load_sec,
  input  logic [7:0] load_min,
  input  logic [7:0] load_hr,
  output logic [7:0] val_sec,
  output logic [7:0] val_min,
  output logic [7:0] val_hr,
  output logic [1:0] field,
  output logic       step
);

  localparam int CMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] DLY_LD = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] PER_LD = CW'(RPT_PERIOD - 1);
  localparam logic [7:0] SEC_TOP = {4'((SEC_MOD - 1) / 10), 4'((SEC_MOD - 1) % 10)};
  localparam logic [7:0] MIN_TOP = {4'((MIN_MOD - 1) / 10), 4'((MIN_MOD - 1) % 10)};
  localparam logic [7:0] HR_TOP  = {4'((HR_MOD - 1) / 10), 4'((HR_MOD - 1) % 10)};

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT, S_HOLD} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          dir, dir_n;
  logic          inc_q, dec_q;
  logic          do_step, step_up;
  logic          up, down, req, prev_req, same;

  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic go_up,
                                          input logic [7:0] top);
    logic [7:0] r;
    if (go_up) begin
      if (v == top)             r = 8'h00;
      else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
      else                      r = {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (v == 8'h00)           r = top;
      else if (v[3:0] == 4'd0)  r = {v[7:4] - 4'd1, 4'd9};
      else                      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // Out-of-range presets collapse to 00 so fields always hold legal values.
  function automatic logic [7:0] bcd_check(input logic [7:0] v, input int m);
    int b;
    logic [7:0] r;
    b = 10 * int'(v[7:4]) + int'(v[3:0]);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || b >= m) r = 8'h00;
    else                                          r = v;
    return r;
  endfunction

  assign up       = inc & ~dec;
  assign down     = dec & ~inc;
  assign req      = inc ^ dec;
  assign prev_req = inc_q ^ dec_q;
  assign same     = dir ? up : down;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dir_n   = dir;
    do_step = 1'b0;
    step_up = dir;
    case (state)
      S_HOLD: if (!inc && !dec) state_n = S_IDLE;
      S_IDLE: begin
        if (req && !prev_req) begin
          do_step = 1'b1;
          step_up = up;
          dir_n   = up;
          cnt_n   = DLY_LD;
          state_n = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (!inc && !dec) begin
          state_n = S_IDLE;
        end else if (same) begin
          if (cnt == '0) begin
            do_step = 1'b1;
            cnt_n   = PER_LD;
            state_n = S_REPEAT;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end else begin
          state_n = S_HOLD;
        end
      end
      default: state_n = S_HOLD;
    endcase
    // load and sel both discard any step and demand a fresh press.
    if (load || sel) begin
      do_step = 1'b0;
      state_n = S_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_HOLD;
      cnt     <= '0;
      dir     <= 1'b1;
      inc_q   <= 1'b1;
      dec_q   <= 1'b1;
      field   <= 2'd0;
      step    <= 1'b0;
      val_sec <= 8'h00;
      val_min <= 8'h00;
      val_hr  <= 8'h00;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dir   <= dir_n;
      inc_q <= inc;
      dec_q <= dec;
      step  <= do_step;
      if (load) begin
        val_sec <= bcd_check(load_sec, SEC_MOD);
        val_min <= bcd_check(load_min, MIN_MOD);
        val_hr  <= bcd_check(load_hr, HR_MOD);
      end else if (sel) begin
        field <= (field == 2'd2) ? 2'd0 : field + 2'd1;
      end else if (do_step) begin
        case (field)
          2'd0:    val_sec <= bcd_next(val_sec, step_up, SEC_TOP);
          2'd1:    val_min <= bcd_next(val_min, step_up, MIN_TOP);
          2'd2:    val_hr  <= bcd_next(val_hr, step_up, HR_TOP);
          default: ;
        endcase
      end
    end
  end

endmodule
